tcp_rx_app_ptr_responder: RTL
=============================

# tcp_rx_app_ptr_responder

NoC endpoint serving the TCP RX application-pointer interface (fbits `TCP_RX_APP_PTR_IF_FBITS`). Application cores send single-flit `tcp_noc_hdr_flit` requests to read a flow's RX buffer head/tail pointers or to commit a new head pointer after consuming data. The block looks up the per-flow pointer memory owned by the TCP engine, validates commits, writes back the head pointer and returns a response header flit to the requester. It is the responder for the app-side pointer initiator.

## Interface
- `SRC_X`, default 0: this tile's NoC X coordinate, placed in response `src_x`.
- `SRC_Y`, default 0: this tile's NoC Y coordinate, placed in response `src_y`.
- `BUF_PTR_W`, default 16: log2 of RX buffer bytes; pointers carry `BUF_PTR_W+1` meaningful bits, the top one being the wrap bit.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `noc_rx_val` / `noc_rx_data` / `noc_rx_rdy`: in 1 / in `NOC_DATA_WIDTH` / out 1; request flits.
- `noc_tx_val` / `noc_tx_data` / `noc_tx_rdy`: out 1 / out `NOC_DATA_WIDTH` / in 1; response flits.
- `ptr_rd_en` out 1, `ptr_rd_flowid` out `MAX_FLOWID_W`: pointer memory read, fixed 1-cycle latency.
- `ptr_rd_head`, `ptr_rd_tail` in `MAX_PAYLOAD_PTR_W+1`: read data, valid the cycle after `ptr_rd_en`.
- `ptr_wr_val` out 1, `ptr_wr_flowid` out `MAX_FLOWID_W`, `ptr_wr_head` out `MAX_PAYLOAD_PTR_W+1`, `ptr_wr_rdy` in 1: head-pointer write, val/rdy.

## Operation
- FSM states: `IDLE`, `RD`, `CHECK`, `WR`, `TX`, `DRAIN`.
- `IDLE`: `noc_rx_rdy`=1. On `noc_rx_val`, register header and move to `RD`, or to `DRAIN` if `msg_len`≠0.
- `DRAIN`: `noc_rx_rdy`=1. Discard `msg_len` body flits with a down-counter, then enter `RD`.
- `RD`: `ptr_rd_en`=1 for one cycle with the registered flowid; move to `CHECK`.
- `CHECK`: capture `ptr_rd_head`/`ptr_rd_tail`.
  - `TCP_APP_PTR_REQ`: response carries the memory head, the memory tail, and length = (tail − head) mod 2^(`BUF_PTR_W`+1), zero-extended; go to `TX`.
  - `TCP_APP_PTR_COMMIT`: new = request `head_ptr`, avail = (tail − old_head) mod 2^(`BUF_PTR_W`+1), adv = (new − old_head) mod 2^(`BUF_PTR_W`+1).
    - adv ≤ avail: go to `WR`.
    - Otherwise: response type `TCP_APP_PTR_NACK`, head and tail echo memory values, no write, go to `TX`.
  - Any other `msg_type`: `TCP_APP_PTR_NACK`, go to `TX`.
- `WR`: hold `ptr_wr_val` until `ptr_wr_rdy`. Response is `TCP_APP_PTR_ACK` with head = new, tail = memory tail, length = avail − adv; go to `TX`.
- `TX`: hold `noc_tx_val` with a stable flit until `noc_tx_rdy`, then return to `IDLE`.
- Response header fields:
  - dst_x/dst_y/dst_fbits = request src_x/src_y/src_fbits.
  - src_x/src_y = `SRC_X`/`SRC_Y`; src_fbits = `TCP_RX_APP_PTR_IF_FBITS`.
  - msg_len = 0; flowid echoed; padding = 0.
- Pointer arithmetic masks to `BUF_PTR_W+1` bits; upper pointer bits are output as 0.
- adv = avail (buffer emptied) is legal. adv = 0 is a legal no-op commit that still writes.

## Timing
- Reset values: `noc_rx_rdy`=0 during reset and 1 from the first cycle after; `noc_tx_val`=0; `ptr_rd_en`=0; `ptr_wr_val`=0; all data outputs 0; state `IDLE`.
- Header accepted at T (msg_len 0):
  - `ptr_rd_en` at T+1.
  - REQ: `noc_tx_val` at T+3.
  - COMMIT: `ptr_wr_val` at T+3; `noc_tx_val` the cycle after the write handshake (T+4 if `ptr_wr_rdy` is high).
- One request in flight; `noc_rx_rdy`=0 outside `IDLE`/`DRAIN`. Peak throughput is one REQ per 4 cycles.
- `rst` mid-operation aborts the pending request without a response or write. Outputs return to reset values the next cycle.
- A concurrent engine write to the same flow's tail between `RD` and `TX` is not reflected; the response reports the tail as sampled.

## Configuration
- `TCP_APP_PTR_COMMIT_CHECK_EN` defined: bounds check active as above.
- Not defined: every COMMIT goes `CHECK`→`WR` unconditionally with ACK, length = (tail − new) mod 2^(`BUF_PTR_W`+1). NACK is produced only for unknown `msg_type`.

## Structure
- Add `TCP_APP_PTR_REQ`, `TCP_APP_PTR_COMMIT`, `TCP_APP_PTR_ACK`, `TCP_APP_PTR_NACK` msg_type constants and `TCP_APP_PTR_RESP_FBITS` alias to the shared beehive TCP message package. Reuse `tcp_noc_hdr_flit` unchanged.
- One sub-module: `tcp_ptr_arith`, combinational avail/adv/length/commit-ok computation, parameterised by `BUF_PTR_W`.

## Test plan
- REQ flow 5, memory head=0x0010, tail=0x0110 -> response at T+3 with length 0x100, head 0x10, tail 0x110, dst = requester src, flowid 5.
- COMMIT flow 2, old head 0x1FFF0, tail 0x00010 (wrapped, `BUF_PTR_W`=16), new 0x00000 -> write head 0x00000, ACK with length 0x10.
- COMMIT new beyond tail (head 0x10, tail 0x20, new 0x30) -> NACK, no `ptr_wr_val`. With macro undefined: write 0x30, ACK with length 0x1FFF0.
- `noc_tx_rdy` low for 5 cycles and `ptr_wr_rdy` low for 3 cycles -> flit and write held stable; a second header is not accepted until `IDLE`.
- REQ with msg_len=2 -> two body flits drained, then normal response.
- `rst` asserted in `WR` -> no write, no response, `noc_rx_rdy`=1 one cycle after reset is released.

Source files
------------

// File: rtl/tcp_rx_app_ptr_responder_pkg.sv
// tcp_rx_app_ptr_responder_pkg: shared TCP NoC header flit, widths and app-pointer message codes.
package tcp_rx_app_ptr_responder_pkg;
   localparam int MAX_FLOWID_W      = 8;
   localparam int MAX_PAYLOAD_PTR_W = 31;
   localparam int MSG_LEN_W         = 8;
   localparam int NOC_DATA_WIDTH    = 256;

   localparam logic [3:0] TCP_RX_APP_PTR_IF_FBITS = 4'd5;
   localparam logic [3:0] TCP_APP_PTR_RESP_FBITS  = TCP_RX_APP_PTR_IF_FBITS;

   localparam logic [7:0] TCP_APP_PTR_REQ    = 8'h40;
   localparam logic [7:0] TCP_APP_PTR_COMMIT = 8'h41;
   localparam logic [7:0] TCP_APP_PTR_ACK    = 8'h42;
   localparam logic [7:0] TCP_APP_PTR_NACK   = 8'h43;

   typedef struct packed {
      logic [7:0]                   dst_x;
      logic [7:0]                   dst_y;
      logic [3:0]                   dst_fbits;
      logic [MSG_LEN_W-1:0]         msg_len;
      logic [7:0]                   src_x;
      logic [7:0]                   src_y;
      logic [3:0]                   src_fbits;
      logic [7:0]                   msg_type;
      logic [MAX_FLOWID_W-1:0]      flowid;
      logic [MAX_PAYLOAD_PTR_W:0]   head_ptr;
      logic [MAX_PAYLOAD_PTR_W:0]   tail_ptr;
      logic [MAX_PAYLOAD_PTR_W:0]   length;
      logic [95:0]                  padding;
   } tcp_noc_hdr_flit;

   typedef enum logic [2:0] {IDLE, RD, CHECK, WR, TX, DRAIN} app_ptr_state_e;
endpackage

// File: rtl/tcp_rx_app_ptr_responder_arith.sv
// tcp_ptr_arith: masked RX pointer distances and commit bounds check.
// Bounds check is active only when TCP_APP_PTR_COMMIT_CHECK_EN is defined.
module tcp_ptr_arith
   import tcp_rx_app_ptr_responder_pkg::*;
#(
   parameter int BUF_PTR_W = 16
) (
   input  logic [MAX_PAYLOAD_PTR_W:0] old_head,
   input  logic [MAX_PAYLOAD_PTR_W:0] tail,
   input  logic [MAX_PAYLOAD_PTR_W:0] new_head,
   output logic [MAX_PAYLOAD_PTR_W:0] old_masked,
   output logic [MAX_PAYLOAD_PTR_W:0] tail_masked,
   output logic [MAX_PAYLOAD_PTR_W:0] new_masked,
   output logic [MAX_PAYLOAD_PTR_W:0] req_len,
   output logic [MAX_PAYLOAD_PTR_W:0] ack_len,
   output logic                       commit_ok
);
   localparam int PW = MAX_PAYLOAD_PTR_W + 1;
   localparam logic [PW-1:0] MASK = PW'((64'd1 << (BUF_PTR_W + 1)) - 64'd1);

   assign old_masked  = old_head & MASK;
   assign tail_masked = tail & MASK;
   assign new_masked  = new_head & MASK;
   assign req_len     = (tail - old_head) & MASK;
   // avail - adv reduces to tail - new modulo the buffer pointer space
   assign ack_len     = (tail - new_head) & MASK;
`ifdef TCP_APP_PTR_COMMIT_CHECK_EN
   logic [PW-1:0] adv;
   assign adv       = (new_head - old_head) & MASK;
   assign commit_ok = adv <= req_len;
`else
   assign commit_ok = 1'b1;
`endif
endmodule

// File: rtl/tcp_rx_app_ptr_responder.sv
// tcp_rx_app_ptr_responder: NoC endpoint serving RX app head/tail reads and head commits.
// Commit bounds check selected by TCP_APP_PTR_COMMIT_CHECK_EN.
module tcp_rx_app_ptr_responder
   import tcp_rx_app_ptr_responder_pkg::*;
#(
   parameter int SRC_X     = 0,
   parameter int SRC_Y     = 0,
   parameter int BUF_PTR_W = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         noc_rx_val,
   input  logic [NOC_DATA_WIDTH-1:0]    noc_rx_data,
   output logic                         noc_rx_rdy,
   output logic                         noc_tx_val,
   output logic [NOC_DATA_WIDTH-1:0]    noc_tx_data,
   input  logic                         noc_tx_rdy,
   output logic                         ptr_rd_en,
   output logic [MAX_FLOWID_W-1:0]      ptr_rd_flowid,
   input  logic [MAX_PAYLOAD_PTR_W:0]   ptr_rd_head,
   input  logic [MAX_PAYLOAD_PTR_W:0]   ptr_rd_tail,
   output logic                         ptr_wr_val,
   output logic [MAX_FLOWID_W-1:0]      ptr_wr_flowid,
   output logic [MAX_PAYLOAD_PTR_W:0]   ptr_wr_head,
   input  logic                         ptr_wr_rdy
);
   app_ptr_state_e state_q, state_d;
   tcp_noc_hdr_flit rx_hdr, hdr_q, resp_q, resp_d;
   logic [MSG_LEN_W-1:0] cnt_q;
   logic [MAX_PAYLOAD_PTR_W:0] wr_head_q, head_m, tail_m, new_m, req_len, ack_len;
   logic commit_ok, is_req, is_commit, do_wr, unused_hdr;

   assign rx_hdr    = tcp_noc_hdr_flit'(noc_rx_data);
   assign is_req    = hdr_q.msg_type == TCP_APP_PTR_REQ;
   assign is_commit = hdr_q.msg_type == TCP_APP_PTR_COMMIT;
   assign do_wr     = is_commit && commit_ok;
   assign unused_hdr = ^{hdr_q.dst_x, hdr_q.dst_y, hdr_q.dst_fbits, hdr_q.msg_len,
                         hdr_q.tail_ptr, hdr_q.length, hdr_q.padding};

   tcp_ptr_arith #(.BUF_PTR_W(BUF_PTR_W)) u_arith (
      .old_head(ptr_rd_head), .tail(ptr_rd_tail), .new_head(hdr_q.head_ptr),
      .old_masked(head_m), .tail_masked(tail_m), .new_masked(new_m),
      .req_len(req_len), .ack_len(ack_len), .commit_ok(commit_ok)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (noc_rx_val) state_d = rx_hdr.msg_len != '0 ? DRAIN : RD;
         DRAIN:   if (noc_rx_val && cnt_q == MSG_LEN_W'(1)) state_d = RD;
         RD:      state_d = CHECK;
         CHECK:   state_d = do_wr ? WR : TX;
         WR:      if (ptr_wr_rdy) state_d = TX;
         TX:      if (noc_tx_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      resp_d           = '0;
      resp_d.dst_x     = hdr_q.src_x;
      resp_d.dst_y     = hdr_q.src_y;
      resp_d.dst_fbits = hdr_q.src_fbits;
      resp_d.src_x     = 8'(SRC_X);
      resp_d.src_y     = 8'(SRC_Y);
      resp_d.src_fbits = TCP_APP_PTR_RESP_FBITS;
      resp_d.flowid    = hdr_q.flowid;
      resp_d.msg_type  = is_req || do_wr ? TCP_APP_PTR_ACK : TCP_APP_PTR_NACK;
      resp_d.head_ptr  = do_wr ? new_m : head_m;
      resp_d.tail_ptr  = tail_m;
      resp_d.length    = is_req ? req_len : do_wr ? ack_len : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hdr_q     <= '0;
         resp_q    <= '0;
         cnt_q     <= '0;
         wr_head_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && noc_rx_val) begin
            hdr_q <= rx_hdr;
            cnt_q <= rx_hdr.msg_len;
         end
         if (state_q == DRAIN && noc_rx_val) cnt_q <= cnt_q - MSG_LEN_W'(1);
         // response and write data are frozen here so WR/TX hold them stable
         if (state_q == CHECK) begin
            resp_q    <= resp_d;
            wr_head_q <= new_m;
         end
      end
   end

   assign noc_rx_rdy    = !rst && (state_q == IDLE || state_q == DRAIN);
   assign noc_tx_val    = state_q == TX;
   assign noc_tx_data   = resp_q;
   assign ptr_rd_en     = state_q == RD;
   assign ptr_rd_flowid = hdr_q.flowid;
   assign ptr_wr_val    = state_q == WR;
   assign ptr_wr_flowid = hdr_q.flowid;
   assign ptr_wr_head   = wr_head_q;
endmodule
